// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Writeback stage owning the single regfile write port. Each cycle it issues
// at most one register write, chosen from:
//   - the single-cycle ALU pipe (highest priority, never stalled), or
//   - the head of a small FIFO that buffers long-latency results
//     (LSU load returns and MULDIV results), drained on idle ALU cycles.
// A pending-register mask tells decode which destinations still sit in the
// FIFO so it can hold off dependent or overwriting instructions.
//
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   alu_we_i/_rd_addr_i/_data  ALU result (no backpressure)
//   lsu_valid_i/lsu_ready_o    LSU load result handshake (+ rd addr/data)
//   md_valid_i/md_ready_o      MULDIV result handshake (+ rd addr/data)
//   rd_we_o/rd_addr_o/rd_data_o registered regfile write port
//   pend_mask_o                one bit per register targeted by a FIFO entry
//   fifo_full_o                FIFO holds DEPTH entries
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,

  input  logic               alu_we_i,
  input  logic [4:0]         alu_rd_addr_i,
  input  logic [XLEN-1:0]    alu_rd_data_i,

  input  logic               lsu_valid_i,
  output logic               lsu_ready_o,
  input  logic [4:0]         lsu_rd_addr_i,
  input  logic [XLEN-1:0]    lsu_rd_data_i,

  input  logic               md_valid_i,
  output logic               md_ready_o,
  input  logic [4:0]         md_rd_addr_i,
  input  logic [XLEN-1:0]    md_rd_data_i,

  output logic               rd_we_o,
  output logic [4:0]         rd_addr_o,
  output logic [XLEN-1:0]    rd_data_o,

  output logic [REG_NUM-1:0] pend_mask_o,
  output logic               fifo_full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  // Round-robin pointer: names the source that wins the next tie.
  typedef enum logic {RrLsu, RrMd} rr_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rr_e               r_rr;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_rptr;
  logic [AW-1:0]     r_wptr;
  logic [DEPTH-1:0]  r_valid;
  logic [4:0]        r_addr [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];

  logic              r_rd_we;
  logic [4:0]        r_rd_addr;
  logic [XLEN-1:0]   r_rd_data;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  rr_e               w_rr;
  logic              w_full;
  logic              w_empty;
  logic              w_lsu_hs;
  logic              w_md_hs;
  logic              w_push;
  logic [4:0]        w_push_addr;
  logic [XLEN-1:0]   w_push_data;
  logic              w_alu_sel;
  logic              w_pop;
  logic [CW-1:0]     w_count;
  logic              w_rd_we;
  logic [4:0]        w_rd_addr;
  logic [XLEN-1:0]   w_rd_data;
  logic [REG_NUM-1:0] w_pend;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Readys come only from registered state, so a pop in the same cycle never
  // opens a slot early; a full FIFO refuses both sources outright.
  assign lsu_ready_o = !w_full && (!md_valid_i  || (r_rr == RrLsu));
  assign md_ready_o  = !w_full && (!lsu_valid_i || (r_rr == RrMd));

  assign w_lsu_hs = lsu_valid_i && lsu_ready_o;
  assign w_md_hs  = md_valid_i  && md_ready_o;

  // Results to x0 are accepted and dropped so the producer is not left hanging.
  always_comb begin
    w_push      = 1'b0;
    w_push_addr = lsu_rd_addr_i;
    w_push_data = lsu_rd_data_i;
    w_rr        = r_rr;
    if (w_lsu_hs) begin
      w_push      = (lsu_rd_addr_i != 5'd0);
      w_push_addr = lsu_rd_addr_i;
      w_push_data = lsu_rd_data_i;
      w_rr        = RrMd;
    end else if (w_md_hs) begin
      w_push      = (md_rd_addr_i != 5'd0);
      w_push_addr = md_rd_addr_i;
      w_push_data = md_rd_data_i;
      w_rr        = RrLsu;
    end
  end

  // ALU writes to x0 are no-ops and leave the port free for a FIFO drain.
  assign w_alu_sel = alu_we_i && (alu_rd_addr_i != 5'd0);
  // Pop uses the registered count: a fresh entry can only drain next cycle.
  assign w_pop     = !w_alu_sel && !w_empty;

  always_comb begin
    w_count = r_count;
    if (w_push && !w_pop) begin
      w_count = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count = r_count - CW'(1);
    end
  end

  // Write-port select; address/data hold their last value when idle.
  always_comb begin
    w_rd_we   = 1'b0;
    w_rd_addr = r_rd_addr;
    w_rd_data = r_rd_data;
    if (w_alu_sel) begin
      w_rd_we   = 1'b1;
      w_rd_addr = alu_rd_addr_i;
      w_rd_data = alu_rd_data_i;
    end else if (w_pop) begin
      w_rd_we   = 1'b1;
      w_rd_addr = r_addr[r_rptr];
      w_rd_data = r_data[r_rptr];
    end
  end

  // Pending mask: OR of one-hot destinations of all live entries.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        for (int r = 0; r < REG_NUM; r++) begin
          if (r_addr[i] == 5'(r)) begin
            w_pend[r] = 1'b1;
          end
        end
      end
    end
    w_pend[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rr    <= RrLsu;
      r_count <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_rr    <= w_rr;
      r_count <= w_count;
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + AW'(1);
      end
      // Push slot differs from the pop slot unless the FIFO is empty, and an
      // empty FIFO never pops, so the two updates cannot collide.
      if (w_push) begin
        r_valid[r_wptr] <= 1'b1;
        r_addr[r_wptr]  <= w_push_addr;
        r_data[r_wptr]  <= w_push_data;
        r_wptr          <= r_wptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_we   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_we   <= w_rd_we;
      r_rd_addr <= w_rd_addr;
      r_rd_data <= w_rd_data;
    end
  end

  assign rd_we_o     = r_rd_we;
  assign rd_addr_o   = r_rd_addr;
  assign rd_data_o   = r_rd_data;
  assign pend_mask_o = w_pend;
  assign fifo_full_o = w_full;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(w_lsu_hs && w_md_hs));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    r_count <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(w_push && w_full));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            alu_we_i;
  logic [4:0]      alu_rd_addr_i;
  logic [XLEN-1:0] alu_rd_data_i;
  logic            lsu_valid_i;
  logic            lsu_ready_o;
  logic [4:0]      lsu_rd_addr_i;
  logic [XLEN-1:0] lsu_rd_data_i;
  logic            md_valid_i;
  logic            md_ready_o;
  logic [4:0]      md_rd_addr_i;
  logic [XLEN-1:0] md_rd_data_i;
  logic            rd_we_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic [31:0]     pend_mask_o;
  logic            fifo_full_o;

  int n_checks = 0;
  int n_pass   = 0;

  wb_arbiter #(
    .XLEN    (XLEN),
    .REG_NUM (32),
    .DEPTH   (4)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .alu_we_i      (alu_we_i),
    .alu_rd_addr_i (alu_rd_addr_i),
    .alu_rd_data_i (alu_rd_data_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_rd_addr_i (lsu_rd_addr_i),
    .lsu_rd_data_i (lsu_rd_data_i),
    .md_valid_i    (md_valid_i),
    .md_ready_o    (md_ready_o),
    .md_rd_addr_i  (md_rd_addr_i),
    .md_rd_data_i  (md_rd_data_i),
    .rd_we_o       (rd_we_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o),
    .pend_mask_o   (pend_mask_o),
    .fifo_full_o   (fifo_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and registered outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".we"},   64'(rd_we_o),   64'd1);
    check({tag, ".addr"}, 64'(rd_addr_o), 64'(a));
    check({tag, ".data"}, 64'(rd_data_o), 64'(d));
  endtask

  initial begin
    rst_n_i       = 1'b0;
    alu_we_i      = 1'b0;
    alu_rd_addr_i = '0;
    alu_rd_data_i = '0;
    lsu_valid_i   = 1'b0;
    lsu_rd_addr_i = '0;
    lsu_rd_data_i = '0;
    md_valid_i    = 1'b0;
    md_rd_addr_i  = '0;
    md_rd_data_i  = '0;

    // Reset state
    #3;
    check("rst.we",   64'(rd_we_o),     64'd0);
    check("rst.addr", 64'(rd_addr_o),   64'd0);
    check("rst.data", 64'(rd_data_o),   64'd0);
    check("rst.pend", 64'(pend_mask_o), 64'd0);
    check("rst.full", 64'(fifo_full_o), 64'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    tick();
    check("idle.we", 64'(rd_we_o), 64'd0);

    // Readys when only one source is valid (withdrawn before the edge)
    lsu_valid_i = 1'b1;
    #1;
    check("idle.lsu_rdy", 64'(lsu_ready_o), 64'd1);
    lsu_valid_i = 1'b0;
    md_valid_i  = 1'b1;
    #1;
    check("idle.md_rdy", 64'(md_ready_o), 64'd1);
    md_valid_i = 1'b0;
    tick();

    // ALU only
    alu_we_i      = 1'b1;
    alu_rd_addr_i = 5'd5;
    alu_rd_data_i = 32'hDEAD_BEEF;
    tick();
    check_wr("alu5", 5'd5, 32'hDEAD_BEEF);
    alu_rd_addr_i = 5'd0;
    alu_rd_data_i = 32'h0000_0123;
    tick();
    check("alu0.we", 64'(rd_we_o), 64'd0);

    // Contention: ALU busy 3 cycles, LSU and MULDIV valid together
    alu_rd_addr_i = 5'd1;
    alu_rd_data_i = 32'hA1;
    lsu_valid_i   = 1'b1;
    lsu_rd_addr_i = 5'd3;
    lsu_rd_data_i = 32'h11;
    md_valid_i    = 1'b1;
    md_rd_addr_i  = 5'd7;
    md_rd_data_i  = 32'h22;
    #1;
    check("cont.lsu_rdy", 64'(lsu_ready_o), 64'd1);
    check("cont.md_rdy0", 64'(md_ready_o),  64'd0);
    tick();
    check_wr("cont.alu1", 5'd1, 32'hA1);
    lsu_valid_i = 1'b0;
    #1;
    check("cont.md_rdy1", 64'(md_ready_o),  64'd1);
    check("cont.pend8",   64'(pend_mask_o), 64'h08);
    tick();
    md_valid_i = 1'b0;
    #1;
    check("cont.pend88a", 64'(pend_mask_o), 64'h88);
    tick();
    alu_we_i = 1'b0;
    check("cont.pend88b", 64'(pend_mask_o), 64'h88);
    tick();
    check_wr("cont.x3", 5'd3, 32'h11);
    check("cont.pend80", 64'(pend_mask_o), 64'h80);
    tick();
    check_wr("cont.x7", 5'd7, 32'h22);
    check("cont.pend0", 64'(pend_mask_o), 64'h0);
    tick();
    check("cont.idle", 64'(rd_we_o), 64'd0);

    // Full: ALU busy, four LSU pushes
    alu_we_i      = 1'b1;
    alu_rd_addr_i = 5'd1;
    lsu_valid_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lsu_rd_addr_i = 5'(8 + i);
      lsu_rd_data_i = 32'(32'h100 + i);
      tick();
    end
    lsu_rd_addr_i = 5'd12;
    lsu_rd_data_i = 32'h10C;
    #1;
    check("full.flag",  64'(fifo_full_o), 64'd1);
    check("full.pend",  64'(pend_mask_o), 64'hF00);
    check("full.rdy_a", 64'(lsu_ready_o), 64'd0);
    alu_we_i = 1'b0;
    #1;
    check("full.rdy_drain", 64'(lsu_ready_o), 64'd0);
    tick();
    check_wr("full.x8", 5'd8, 32'h100);
    #1;
    check("full.flag0", 64'(fifo_full_o), 64'd0);
    check("full.rdy1",  64'(lsu_ready_o), 64'd1);
    tick();
    check_wr("full.x9", 5'd9, 32'h101);
    lsu_valid_i = 1'b0;
    tick();
    check_wr("full.x10", 5'd10, 32'h102);
    tick();
    check_wr("full.x11", 5'd11, 32'h103);
    tick();
    check_wr("full.x12", 5'd12, 32'h10C);
    tick();
    check("full.idle", 64'(rd_we_o),     64'd0);
    check("full.pend0", 64'(pend_mask_o), 64'd0);

    // x0 drop from MULDIV
    md_valid_i   = 1'b1;
    md_rd_addr_i = 5'd0;
    md_rd_data_i = 32'h55;
    #1;
    check("x0.md_rdy", 64'(md_ready_o), 64'd1);
    tick();
    md_valid_i = 1'b0;
    check("x0.pend", 64'(pend_mask_o), 64'd0);
    check("x0.full", 64'(fifo_full_o), 64'd0);
    tick();
    check("x0.nowr_a", 64'(rd_we_o), 64'd0);
    tick();
    check("x0.nowr_b", 64'(rd_we_o), 64'd0);

    // Async reset mid-drain with two entries queued
    alu_we_i      = 1'b1;
    alu_rd_addr_i = 5'd2;
    lsu_valid_i   = 1'b1;
    lsu_rd_addr_i = 5'd20;
    lsu_rd_data_i = 32'h200;
    tick();
    lsu_valid_i  = 1'b0;
    md_valid_i   = 1'b1;
    md_rd_addr_i = 5'd21;
    md_rd_data_i = 32'h210;
    tick();
    md_valid_i = 1'b0;
    alu_we_i   = 1'b0;
    #1;
    check("ar.pend", 64'(pend_mask_o), 64'h0030_0000);
    tick();
    check_wr("ar.x20", 5'd20, 32'h200);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("ar.we",   64'(rd_we_o),     64'd0);
    check("ar.addr", 64'(rd_addr_o),   64'd0);
    check("ar.data", 64'(rd_data_o),   64'd0);
    check("ar.pend0", 64'(pend_mask_o), 64'd0);
    #2;
    rst_n_i = 1'b1;
    tick();
    check("ar.stale_a", 64'(rd_we_o), 64'd0);
    tick();
    check("ar.stale_b", 64'(rd_we_o), 64'd0);
    check("ar.pend1",   64'(pend_mask_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage that owns the regfile write port (rd_addr/rd_data/rd_we) and feeds it one write per cycle.
- Merges three result sources: the single-cycle ALU pipe (never stalled), the LSU load return and the MULDIV unit (both valid/ready).
- Long-latency results are buffered in a small FIFO and drained on idle ALU cycles.
- Exports a pending-register mask so decode can stall on RAW/WAW hazards against buffered results.

Parameters:
- XLEN, 32, data width (matches `XLEN).
- REG_NUM, 32, architectural register count (matches `REG_NUM).
- DEPTH, 4, pending FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  asynchronous active-low reset.
- alu_we_i  input  1  ALU result valid this cycle; no backpressure.
- alu_rd_addr_i  input  5  ALU destination register.
- alu_rd_data_i  input  XLEN  ALU result.
- lsu_valid_i  input  1  load result valid.
- lsu_ready_o  output  1  load result accepted when high with valid.
- lsu_rd_addr_i  input  5  load destination.
- lsu_rd_data_i  input  XLEN  load data.
- md_valid_i  input  1  MULDIV result valid.
- md_ready_o  output  1  MULDIV result accepted when high with valid.
- md_rd_addr_i  input  5  MULDIV destination.
- md_rd_data_i  input  XLEN  MULDIV result.
- rd_we_o  output  1  regfile write enable (registered).
- rd_addr_o  output  5  regfile write address (registered).
- rd_data_o  output  XLEN  regfile write data (registered).
- pend_mask_o  output  REG_NUM  bit r set while any valid FIFO entry targets r.
- fifo_full_o  output  1  FIFO holds DEPTH entries.

Behaviour:
- Reset (rst_n_i low, async): rd_we_o=0, rd_addr_o=0, rd_data_o=0. FIFO emptied: count=0, read/write pointers=0, all entry valids 0. RR pointer favours LSU. pend_mask_o=0, fifo_full_o=0.
- Reset asserted mid-operation discards all buffered results; no write issues on the release edge.
- Output register latency is 1 cycle. The write selected in cycle N appears on rd_*_o in cycle N+1, held for exactly one cycle.
- Write select, cycle N, in priority order:
  - if alu_we_i and alu_rd_addr_i != 0: select the ALU result;
  - else if FIFO not empty: select the FIFO head and pop it;
  - else rd_we_o=0 next cycle.
  - ALU writes to x0 produce no write and do not block a FIFO drain.
- Enqueue:
  - At most one slow result per cycle.
  - Ready depends only on the registered count and the RR state, never on the dequeue in the same cycle. When full, both readys are low even if a pop occurs this cycle.
  - Arbitration when both valid and not full: RR pointer grants one source. The grantee's ready is high, the other's is low. On a handshake the pointer moves to favour the other source.
  - With only one valid source, that source's ready = !full.
  - A handshake whose rd_addr==0 is accepted (ready high) but not enqueued; count is unchanged.
- FIFO: circular, pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged.
  - Push into empty: the entry may pop the next cycle at the earliest; there is no same-cycle bypass.
- pend_mask_o is the combinational OR over valid entries of one-hot(rd_addr). Bit 0 is always 0. A bit clears the cycle after the last matching entry pops.
- Ordering is decode's responsibility. Decode must not issue an ALU op whose rd or rs is set in pend_mask_o. No WAW check is done here.
- fifo_full_o = (count==DEPTH), registered-count based.
- Data passes through unmodified; no width conversion.

Test Plan:
- Reset then idle: rd_we_o=0, pend_mask_o=0, lsu_ready_o=1 and md_ready_o=1 when the matching valid is high.
- ALU only: alu_we_i=1, rd=5, data=0xDEADBEEF in cycle N -> rd_we_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF in N+1; alu rd=0 -> rd_we_o=0.
- Contention:
  - Stimulus: lsu rd=3 data=0x11 and md rd=7 data=0x22 valid together while the ALU writes rd=1 for 3 cycles.
  - Required: lsu is accepted first, md next. pend_mask_o=0x88 while both are buffered. After the ALU idles, writes x3=0x11 then x7=0x22 in consecutive cycles. The mask then returns to 0.
- Full:
  - Stimulus: ALU busy every cycle; push 4 LSU results (rd 8..11).
  - Required: fifo_full_o=1; a 5th valid sees lsu_ready_o=0 even on a drain cycle. After one pop, ready=1 the next cycle.
- x0 drop: md valid rd=0 data=0x55 -> md_ready_o=1, count unchanged, no write, pend_mask_o bit 0 stays 0.
- Async reset mid-drain: assert rst_n_i low between clock edges with 2 entries queued -> outputs go to 0 immediately; after release no stale writes appear.
